// File: rtl/multi_cycle_decoder.sv
// multi_cycle_decoder: control FSM for a classic multi-cycle MIPS-style datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction. It times out
// stalled memory accesses and traps on unsupported opcodes or timeouts.
// Optional feature: define MULTI_CYCLE_DECODER_JUMP_EN to support the J opcode.
module multi_cycle_decoder #(
    parameter int OP_W     = 6,
    parameter int ALU_OP_W = 6,
    parameter int WAIT_MAX = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     instr_op_i,
    input  logic                zero_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic [1:0]          pc_src_o,
    output logic                ir_write_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                reg_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                alu_src_b_o,
    output logic                immed_exten_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [2:0]          state_o,
    output logic                illegal_o,
    output logic                timeout_o
);

    // State encodings are visible on state_o, so they are fixed explicitly.
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    // Supported opcodes, sized to the configured opcode width.
    localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
`ifdef MULTI_CYCLE_DECODER_JUMP_EN
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
`endif

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    // Registered state.
    state_t          state_q;
    state_t          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;
    logic [7:0]      wait_cnt_q;
    logic [7:0]      wait_cnt_d;
    logic            illegal_q;
    logic            illegal_d;
    logic            timeout_q;
    logic            timeout_d;
    logic            mem_waiting;

    // Raw decoded controls before the reset gate.
    logic                pc_write_raw;
    logic [1:0]          pc_src_raw;
    logic                ir_write_raw;
    logic                mem_read_raw;
    logic                mem_write_raw;
    logic                reg_write_raw;
    logic                reg_dst_raw;
    logic                mem_to_reg_raw;
    logic                alu_src_b_raw;
    logic                immed_exten_raw;
    logic [ALU_OP_W-1:0] alu_op_raw;

    // Operand selection shared by EXEC, MEM and WB so the ALU path stays stable.
    logic op_uses_imm;
    logic op_zero_ext;

    // True for every opcode the decoder knows how to execute.
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_ADDI) || (op == OP_ORI) ||
             (op == OP_BEQ) || (op == OP_LW) || (op == OP_SW);
`ifdef MULTI_CYCLE_DECODER_JUMP_EN
        ok = ok || (op == OP_J);
`endif
        return ok;
    endfunction

    // State, latched opcode, wait counter and sticky trap flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= FETCH;
            op_q       <= '0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic, opcode capture, trap causes and wait-counter update.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        mem_waiting = 1'b0;

        case (state_q)
            FETCH: begin
                if (mem_ready_i) begin
                    state_d = DECODE;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_waiting = 1'b1;
                end
            end
            DECODE: begin
                op_d = instr_op_i;
                if (op_supported(instr_op_i)) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_R, OP_ADDI, OP_ORI: state_d = WB;
                    OP_LW, OP_SW:          state_d = MEM;
                    OP_BEQ:                state_d = FETCH;
`ifdef MULTI_CYCLE_DECODER_JUMP_EN
                    OP_J:                  state_d = FETCH;
`endif
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LW) ? WB : FETCH;
                end else if (wait_cnt_q == WAIT_LIMIT) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    mem_waiting = 1'b1;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (mem_waiting) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // Immediate-operand decode of the latched opcode.
    always_comb begin
        op_uses_imm = (op_q == OP_ADDI) || (op_q == OP_ORI) ||
                      (op_q == OP_LW)   || (op_q == OP_SW);
        op_zero_ext = (op_q == OP_ORI);
    end

    // Control outputs decoded from the state register and latched opcode.
    always_comb begin
        pc_write_raw    = 1'b0;
        pc_src_raw      = 2'd0;
        ir_write_raw    = 1'b0;
        mem_read_raw    = 1'b0;
        mem_write_raw   = 1'b0;
        reg_write_raw   = 1'b0;
        reg_dst_raw     = 1'b0;
        mem_to_reg_raw  = 1'b0;
        alu_src_b_raw   = 1'b0;
        immed_exten_raw = 1'b0;
        alu_op_raw      = '0;

        if (state_q != FETCH) begin
            alu_op_raw[OP_W-1:0] = op_q;
        end

        case (state_q)
            FETCH: begin
                mem_read_raw = 1'b1;
                if (mem_ready_i) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    pc_src_raw   = 2'd0;
                end
            end
            EXEC: begin
                alu_src_b_raw   = op_uses_imm;
                immed_exten_raw = op_zero_ext;
                if (op_q == OP_BEQ) begin
                    pc_write_raw = zero_i;
                    pc_src_raw   = 2'd1;
                end
`ifdef MULTI_CYCLE_DECODER_JUMP_EN
                if (op_q == OP_J) begin
                    pc_write_raw = 1'b1;
                    pc_src_raw   = 2'd2;
                end
`endif
            end
            MEM: begin
                alu_src_b_raw   = op_uses_imm;
                immed_exten_raw = op_zero_ext;
                mem_read_raw    = (op_q == OP_LW);
                mem_write_raw   = (op_q == OP_SW);
            end
            WB: begin
                alu_src_b_raw   = op_uses_imm;
                immed_exten_raw = op_zero_ext;
                reg_write_raw   = 1'b1;
                reg_dst_raw     = (op_q == OP_R);
                mem_to_reg_raw  = (op_q == OP_LW);
            end
            default: begin
            end
        endcase
    end

    // Reset gates every output low at once, overriding the FETCH decode.
    always_comb begin
        pc_write_o    = rst_i & pc_write_raw;
        pc_src_o      = rst_i ? pc_src_raw : 2'd0;
        ir_write_o    = rst_i & ir_write_raw;
        mem_read_o    = rst_i & mem_read_raw;
        mem_write_o   = rst_i & mem_write_raw;
        reg_write_o   = rst_i & reg_write_raw;
        reg_dst_o     = rst_i & reg_dst_raw;
        mem_to_reg_o  = rst_i & mem_to_reg_raw;
        alu_src_b_o   = rst_i & alu_src_b_raw;
        immed_exten_o = rst_i & immed_exten_raw;
        alu_op_o      = rst_i ? alu_op_raw : '0;
        state_o       = state_q;
        illegal_o     = illegal_q;
        timeout_o     = timeout_q;
    end

endmodule

// File: tb/tb_multi_cycle_decoder.sv
// tb_multi_cycle_decoder: table-driven bench for multi_cycle_decoder plus
// hand-written sequences for timeouts, traps, jump and mid-access reset.
// Honours MULTI_CYCLE_DECODER_JUMP_EN the same way as the design.
module tb_multi_cycle_decoder;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [5:0] instr_op_i;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_write_o;
    logic [1:0] pc_src_o;
    logic       ir_write_o;
    logic       mem_read_o;
    logic       mem_write_o;
    logic       reg_write_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       alu_src_b_o;
    logic       immed_exten_o;
    logic [5:0] alu_op_o;
    logic [2:0] state_o;
    logic       illegal_o;
    logic       timeout_o;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic       immed_exten;
        logic [5:0] alu_op;
        logic       illegal;
        logic       timeout;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       zero;
        logic       ready;
        outs_t      exp;
    } vec_t;

    vec_t vecs[$];

    multi_cycle_decoder #(.OP_W(6), .ALU_OP_W(6), .WAIT_MAX(15)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .instr_op_i   (instr_op_i),
        .zero_i       (zero_i),
        .mem_ready_i  (mem_ready_i),
        .pc_write_o   (pc_write_o),
        .pc_src_o     (pc_src_o),
        .ir_write_o   (ir_write_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .reg_write_o  (reg_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_b_o  (alu_src_b_o),
        .immed_exten_o(immed_exten_o),
        .alu_op_o     (alu_op_o),
        .state_o      (state_o),
        .illegal_o    (illegal_o),
        .timeout_o    (timeout_o)
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    // Arg order: state, pc_write, pc_src, ir_write, mem_read, mem_write,
    // reg_write, reg_dst, mem_to_reg, alu_src_b, immed_exten, alu_op, illegal, timeout.
    function automatic outs_t mk(int st, int pcw, int pcs, int irw, int mr, int mw,
                                 int rw, int rd, int m2r, int asb, int ie, int alu,
                                 int ill = 0, int to = 0);
        outs_t o;
        o.state       = 3'(st);
        o.pc_write    = pcw[0];
        o.pc_src      = 2'(pcs);
        o.ir_write    = irw[0];
        o.mem_read    = mr[0];
        o.mem_write   = mw[0];
        o.reg_write   = rw[0];
        o.reg_dst     = rd[0];
        o.mem_to_reg  = m2r[0];
        o.alu_src_b   = asb[0];
        o.immed_exten = ie[0];
        o.alu_op      = 6'(alu);
        o.illegal     = ill[0];
        o.timeout     = to[0];
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t o;
        o.state       = state_o;
        o.pc_write    = pc_write_o;
        o.pc_src      = pc_src_o;
        o.ir_write    = ir_write_o;
        o.mem_read    = mem_read_o;
        o.mem_write   = mem_write_o;
        o.reg_write   = reg_write_o;
        o.reg_dst     = reg_dst_o;
        o.mem_to_reg  = mem_to_reg_o;
        o.alu_src_b   = alu_src_b_o;
        o.immed_exten = immed_exten_o;
        o.alu_op      = alu_op_o;
        o.illegal     = illegal_o;
        o.timeout     = timeout_o;
        return o;
    endfunction

    function automatic void add_vec(logic [5:0] op, logic zero, logic ready, outs_t exp);
        vec_t v;
        v.op    = op;
        v.zero  = zero;
        v.ready = ready;
        v.exp   = exp;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input logic [5:0] op, input logic zero, input logic ready);
        instr_op_i  = op;
        zero_i      = zero;
        mem_ready_i = ready;
    endtask

    task automatic checkNow(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got state=%0d bits=%h, expected state=%0d bits=%h",
                     name, act.state, act, exp.state, exp);
        end
    endtask

    task automatic checkOutput(input string name, input outs_t exp);
        @(negedge clk_i);
        checkNow(name, exp);
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic stepCheck(input string name, input logic [5:0] op, input logic zero,
                             input logic ready, input outs_t exp);
        applyStimulus(op, zero, ready);
        checkOutput(name, exp);
        nextCycle();
    endtask

    // Reset with ready high, so any leak from the FETCH decode would show.
    task automatic doReset();
        rst_i = 1'b0;
        applyStimulus(OP_ADDI, 1'b0, 1'b1);
        checkOutput("reset_hold", mk(0,0,0,0,0,0,0,0,0,0,0,0));
        nextCycle();
        rst_i = 1'b1;
    endtask

    // Hold ready low and count cycles in the given state until TRAP, bounded.
    task automatic countUntilTrap(input logic [5:0] op, input logic [2:0] st, output int n);
        n = 0;
        applyStimulus(op, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (state_o == 3'd5) break;
            if (state_o == st) n++;
            nextCycle();
        end
    endtask

    // Write-enable exclusivity and pc_src range, every cycle out of reset.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            if ((int'(reg_write_o) + int'(mem_write_o) + int'(pc_write_o)) > 1) begin
                failures++;
                $display("[TB] FAIL write_exclusive: rw=%b mw=%b pcw=%b, expected at most one",
                         reg_write_o, mem_write_o, pc_write_o);
            end
`ifndef MULTI_CYCLE_DECODER_JUMP_EN
            if (pc_src_o == 2'd2) begin
                failures++;
                $display("[TB] FAIL pc_src_range: got 2, expected 0 or 1");
            end
`endif
        end
    end

    initial begin
        int n;
        rst_i = 1'b0;
        applyStimulus(OP_R, 1'b0, 1'b0);

        // ADDI, ready always 1: states 0,1,2,4
        add_vec(OP_ADDI,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_ADDI,0,1, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        add_vec(OP_ADDI,0,1, mk(2,0,0,0,0,0,0,0,0,1,0,8));
        add_vec(OP_ADDI,0,1, mk(4,0,0,0,0,0,1,0,0,1,0,8));
        // ORI: zero-extended immediate
        add_vec(OP_ORI,0,1,  mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_ORI,0,1,  mk(1,0,0,0,0,0,0,0,0,0,0,8));
        add_vec(OP_ORI,0,1,  mk(2,0,0,0,0,0,0,0,0,1,1,13));
        add_vec(OP_ORI,0,1,  mk(4,0,0,0,0,0,1,0,0,1,1,13));
        // R-type: rd destination
        add_vec(OP_R,0,1,    mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_R,0,1,    mk(1,0,0,0,0,0,0,0,0,0,0,13));
        add_vec(OP_R,0,1,    mk(2,0,0,0,0,0,0,0,0,0,0,0));
        add_vec(OP_R,0,1,    mk(4,0,0,0,0,0,1,1,0,0,0,0));
        // BEQ taken
        add_vec(OP_BEQ,1,1,  mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_BEQ,1,1,  mk(1,0,0,0,0,0,0,0,0,0,0,0));
        add_vec(OP_BEQ,1,1,  mk(2,1,1,0,0,0,0,0,0,0,0,4));
        // BEQ not taken
        add_vec(OP_BEQ,0,1,  mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_BEQ,0,1,  mk(1,0,0,0,0,0,0,0,0,0,0,4));
        add_vec(OP_BEQ,0,1,  mk(2,0,1,0,0,0,0,0,0,0,0,4));
        // SW, zero-wait
        add_vec(OP_SW,0,1,   mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_SW,0,1,   mk(1,0,0,0,0,0,0,0,0,0,0,4));
        add_vec(OP_SW,0,1,   mk(2,0,0,0,0,0,0,0,0,1,0,43));
        add_vec(OP_SW,0,1,   mk(3,0,0,0,0,1,0,0,0,1,0,43));
        // LW, ready delayed 3 cycles in MEM
        add_vec(OP_LW,0,1,   mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_LW,0,1,   mk(1,0,0,0,0,0,0,0,0,0,0,43));
        add_vec(OP_LW,0,1,   mk(2,0,0,0,0,0,0,0,0,1,0,35));
        add_vec(OP_LW,0,0,   mk(3,0,0,0,1,0,0,0,0,1,0,35));
        add_vec(OP_LW,0,0,   mk(3,0,0,0,1,0,0,0,0,1,0,35));
        add_vec(OP_LW,0,0,   mk(3,0,0,0,1,0,0,0,0,1,0,35));
        add_vec(OP_LW,0,1,   mk(3,0,0,0,1,0,0,0,0,1,0,35));
        add_vec(OP_LW,0,1,   mk(4,0,0,0,0,0,1,0,1,1,0,35));
        // ADDI with a two-cycle fetch stall
        add_vec(OP_ADDI,0,0, mk(0,0,0,0,1,0,0,0,0,0,0,0));
        add_vec(OP_ADDI,0,0, mk(0,0,0,0,1,0,0,0,0,0,0,0));
        add_vec(OP_ADDI,0,1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        add_vec(OP_ADDI,0,1, mk(1,0,0,0,0,0,0,0,0,0,0,35));
        add_vec(OP_ADDI,0,1, mk(2,0,0,0,0,0,0,0,0,1,0,8));
        add_vec(OP_ADDI,0,1, mk(4,0,0,0,0,0,1,0,0,1,0,8));

        nextCycle();
        doReset();
        foreach (vecs[i]) begin
            stepCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].zero, vecs[i].ready, vecs[i].exp);
        end

        // Fetch timeout: 16 FETCH cycles, then absorbing TRAP
        doReset();
        countUntilTrap(OP_ADDI, 3'd0, n);
        checkValue("fetch_timeout_cycles", n, 16);
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            stepCheck($sformatf("trap_hold%0d", k), OP_ADDI, 1'b1, 1'b1,
                      mk(5,0,0,0,0,0,0,0,0,0,0,0,0,1));
        end

        // Ready on the WAIT_MAX cycle completes normally
        doReset();
        for (int k = 0; k < 15; k++) begin
            applyStimulus(OP_ADDI, 1'b0, 1'b0);
            nextCycle();
        end
        stepCheck("fetch_ready_at_limit", OP_ADDI, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        stepCheck("decode_after_limit", OP_ADDI, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0));

        // MEM timeout on a stalled LW
        doReset();
        stepCheck("lw_to_fetch", OP_LW, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        stepCheck("lw_to_decode", OP_LW, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        stepCheck("lw_to_exec", OP_LW, 1'b0, 1'b1, mk(2,0,0,0,0,0,0,0,0,1,0,35));
        countUntilTrap(OP_LW, 3'd3, n);
        checkValue("mem_timeout_cycles", n, 16);
        checkNow("mem_timeout_trap", mk(5,0,0,0,0,0,0,0,0,0,0,35,0,1));
        nextCycle();

        // Illegal opcode
        doReset();
        stepCheck("bad_fetch", OP_BAD, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        stepCheck("bad_decode", OP_BAD, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        stepCheck("bad_trap", OP_BAD, 1'b0, 1'b1, mk(5,0,0,0,0,0,0,0,0,0,0,63,1,0));

        // Jump: supported only with the macro
        doReset();
        stepCheck("j_fetch", OP_J, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        stepCheck("j_decode", OP_J, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0));
`ifdef MULTI_CYCLE_DECODER_JUMP_EN
        stepCheck("j_exec", OP_J, 1'b0, 1'b1, mk(2,1,2,0,0,0,0,0,0,0,0,2));
        stepCheck("j_back_to_fetch", OP_J, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
`else
        stepCheck("j_illegal", OP_J, 1'b0, 1'b1, mk(5,0,0,0,0,0,0,0,0,0,0,2,1,0));
`endif

        // Reset pulsed during SW in MEM
        doReset();
        stepCheck("sw_fetch", OP_SW, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));
        stepCheck("sw_decode", OP_SW, 1'b0, 1'b1, mk(1,0,0,0,0,0,0,0,0,0,0,0));
        stepCheck("sw_exec", OP_SW, 1'b0, 1'b1, mk(2,0,0,0,0,0,0,0,0,1,0,43));
        applyStimulus(OP_SW, 1'b0, 1'b0);
        checkOutput("sw_mem_before_reset", mk(3,0,0,0,0,1,0,0,0,1,0,43));
        #2;
        rst_i = 1'b0;
        #1;
        checkNow("sw_mem_reset_drop", mk(0,0,0,0,0,0,0,0,0,0,0,0));
        nextCycle();
        rst_i = 1'b1;
        stepCheck("fetch_after_release", OP_SW, 1'b0, 1'b1, mk(0,1,0,1,1,0,0,0,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_decoder.md
MULTI_CYCLE_DECODER -- requirements
Module: multi_cycle_decoder

Interface
REQ-001 Parameter OP_W, default 6: opcode width.
REQ-002 Parameter ALU_OP_W, default 6, must be >= OP_W: ALU op width; opcode is zero-extended onto it.
REQ-003 Parameter WAIT_MAX, default 15, range 1..255: memory-wait timeout in cycles.
REQ-004 clk_i  input  1: single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1: asynchronous, active-low reset.
REQ-006 instr_op_i  input  OP_W: opcode field of the instruction register.
REQ-007 zero_i  input  1: ALU zero flag.
REQ-008 mem_ready_i  input  1: memory completes the current read or write this cycle.
REQ-009 pc_write_o  output  1: PC load enable.
REQ-010 pc_src_o  output  2: PC source; 0 = PC+4, 1 = branch target, 2 = jump target.
REQ-011 ir_write_o  output  1: instruction register load enable.
REQ-012 mem_read_o, mem_write_o  output  1 each: memory request strobes.
REQ-013 reg_write_o  output  1: register file write enable.
REQ-014 reg_dst_o  output  1: write-register select; 0 = rt, 1 = rd.
REQ-015 mem_to_reg_o  output  1: write-back data select; 1 = memory data.
REQ-016 alu_src_b_o  output  1: ALU B operand select; 0 = register, 1 = extended immediate.
REQ-017 immed_exten_o  output  1: immediate extension; 0 = sign-extend, 1 = zero-extend.
REQ-018 alu_op_o  output  ALU_OP_W: zero-extended latched opcode.
REQ-019 state_o  output  3: current state encoding.
REQ-020 illegal_o, timeout_o  output  1 each: sticky trap causes.

Function
REQ-021 State encodings SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all outputs are decoded from the state register and the latched opcode (op_q).
REQ-022 Supported opcodes SHALL be R=000000, ADDI=001000, ORI=001101, BEQ=000100, LW=100011 and SW=101011; J=000010 is supported only under REQ-036.
REQ-023 FETCH SHALL:
- assert mem_read_o every cycle;
- on mem_ready_i, assert ir_write_o and pc_write_o (pc_src_o=0) for that cycle and move to DECODE.
REQ-024 DECODE SHALL:
- load op_q from instr_op_i;
- go to EXEC for a supported opcode;
- go to TRAP and set illegal_o for any other opcode.
REQ-025 EXEC SHALL:
- R-type: alu_src_b_o=0, then go to WB.
- ADDI, LW, SW: alu_src_b_o=1, immed_exten_o=0.
- ORI: alu_src_b_o=1, immed_exten_o=1.
- ADDI and ORI then go to WB; LW and SW then go to MEM.
REQ-026 BEQ in EXEC SHALL set alu_src_b_o=0, drive pc_write_o=zero_i (combinational) with pc_src_o=1, and return to FETCH in exactly one cycle.
REQ-027 MEM SHALL hold mem_read_o (LW) or mem_write_o (SW) until mem_ready_i, then go to WB (LW) or FETCH (SW).
REQ-028 WB SHALL assert reg_write_o for exactly one cycle, with reg_dst_o=1 only for R-type and mem_to_reg_o=1 only for LW, then go to FETCH.
REQ-029 alu_op_o SHALL equal op_q, zero-extended, in every state except FETCH, where it is 0.
REQ-030 Wait counter:
- 8 bits, cleared on every state change;
- increments each FETCH or MEM cycle without mem_ready_i;
- when it reaches WAIT_MAX with mem_ready_i still low, go to TRAP and set timeout_o.
- mem_ready_i on the WAIT_MAX cycle completes the access normally, with no timeout.
REQ-031 TRAP SHALL be absorbing: all strobes are 0 and only reset leaves it.
REQ-032 Latency SHALL be, with zero-wait memory: R/ADDI/ORI 4 cycles, LW 5, SW 4, BEQ 3.
REQ-033 reg_write_o, mem_write_o and pc_write_o SHALL never be asserted in the same cycle.

Reset
REQ-034 While rst_i=0 the block SHALL asynchronously force:
- state to FETCH;
- op_q, the wait counter, illegal_o and timeout_o to 0;
- every strobe to 0, regardless of FETCH decoding.
REQ-035 Reset asserted mid-access (including MEM with mem_write_o high) SHALL drop every strobe in the same cycle; the first access after release is a FETCH.

Configuration
REQ-036 Macro MULTI_CYCLE_DECODER_JUMP_EN:
- Defined: J is supported; EXEC asserts pc_write_o with pc_src_o=2 and returns to FETCH (latency 3).
- Undefined: J is illegal (DECODE goes to TRAP, illegal_o=1) and pc_src_o never equals 2.

Verification
REQ-037 ADDI with mem_ready_i always 1 -> states 0,1,2,4,0; reg_write_o high only in cycle 4 with reg_dst_o=0 and alu_src_b_o=1.
REQ-038 BEQ with zero_i=1, then again with zero_i=0 -> pc_write_o=1 with pc_src_o=1 in EXEC for the first; pc_write_o=0 in EXEC for the second.
REQ-039 LW with mem_ready_i delayed 3 cycles in MEM -> mem_read_o held 4 cycles, then WB with mem_to_reg_o=1.
REQ-040 mem_ready_i held 0 in FETCH with WAIT_MAX=15 -> TRAP after 16 cycles, timeout_o=1, all strobes 0 until reset.
REQ-041 Opcode 111111, and J with the macro undefined -> illegal_o=1 after DECODE; with the macro defined, J -> pc_src_o=2 in EXEC.
REQ-042 rst_i pulsed low during SW in MEM -> mem_write_o drops immediately; state_o=0 after release.
